// File: rtl/wb_cmd_pkg.sv
// Shared types and widths for the Wishbone command initiator.
package wb_cmd_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts bus cycles while enabled; expired flags the cycle whose 1-based count equals LIMIT.
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt;

  // cnt holds the number of completed cycles, so the current cycle is cnt + 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/wb_cmd_initiator.sv
// Turns one command handshake into one Wishbone classic cycle and returns a response.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module wb_cmd_initiator
  import wb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [WB_SELW-1:0] cmd_sel_i,
  input  logic [WB_AW-1:0]   cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  output logic               busy_o,
  output wb_state_e          state_o
);

  wb_state_e state, state_nxt;

  logic               in_bus;
  logic               expired;
  logic               cmd_we;
  logic [WB_SELW-1:0] cmd_sel;
  logic [WB_AW-1:0]   cmd_adr;
  logic [WB_DW-1:0]   cmd_dat;

  assign in_bus = (state == ST_BUS);

  wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .clear   (!in_bus),
    .enable  (in_bus),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ack is checked before expiry so an ack on the final allowed cycle succeeds
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid_i)              state_nxt = ST_BUS;
      ST_BUS:  if (wbm_ack_i || expired)     state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready_i)              state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cmd_we    <= 1'b0;
      cmd_sel   <= '0;
      cmd_adr   <= '0;
      cmd_dat   <= '0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (state == ST_IDLE && cmd_valid_i) begin
        cmd_we  <= cmd_we_i;
        cmd_sel <= cmd_sel_i;
        cmd_adr <= cmd_adr_i;
        cmd_dat <= cmd_dat_i;
      end
      if (in_bus && wbm_ack_i) begin
        rsp_dat_o <= cmd_we ? '0 : wbm_dat_i;
        rsp_err_o <= 1'b0;
      end else if (in_bus && expired) begin
        rsp_dat_o <= '0;
        rsp_err_o <= 1'b1;
      end
    end
  end

  // Bus strobes decode from state so an asynchronous reset drops them at once
  assign cmd_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign busy_o      = (state != ST_IDLE);
  assign state_o     = state;
  assign wbm_cyc_o   = in_bus;
  assign wbm_stb_o   = in_bus;
  assign wbm_we_o    = in_bus ? cmd_we  : 1'b0;
  assign wbm_sel_o   = in_bus ? cmd_sel : '0;
  assign wbm_adr_o   = in_bus ? cmd_adr : '0;
  assign wbm_dat_o   = in_bus ? cmd_dat : '0;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: write, read, timeout, late ack, backpressure, reset abort.
module tb_wb_cmd_initiator;
  import wb_cmd_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic        wbm_ack = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy;
  wb_state_e   state;

  int n_checks = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];

  // responder model state
  int          ack_at = 0;
  logic [31:0] rd_data = '0;
  int          bus_cnt = 0;
  int          stb_cycles = 0;
  logic [31:0] obs_adr = '0, obs_dat = '0;
  logic [3:0]  obs_sel = '0;
  logic        obs_we = 1'b0;
  logic        unstable = 1'b0;

  wb_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_sel_i   (cmd_sel),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack),
    .wbm_dat_i   (wbm_dat_i),
    .busy_o      (busy),
    .state_o     (state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Wishbone responder: acks on bus cycle ack_at (0 = never), records the strobed request
  always @(negedge clk) begin
    if (wbm_cyc && wbm_stb) begin
      bus_cnt = bus_cnt + 1;
      stb_cycles = stb_cycles + 1;
      if (bus_cnt == 1) begin
        obs_adr = wbm_adr;
        obs_dat = wbm_dat_o;
        obs_sel = wbm_sel;
        obs_we  = wbm_we;
      end else if (obs_adr !== wbm_adr || obs_dat !== wbm_dat_o ||
                   obs_sel !== wbm_sel || obs_we !== wbm_we) begin
        unstable = 1'b1;
      end
      wbm_ack   = (bus_cnt == ack_at);
      wbm_dat_i = rd_data;
    end else begin
      bus_cnt = 0;
      wbm_ack = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int waited = 0;
    while (!rsp_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int waited = 0;
    while (busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Drive one command with rsp_ready high and check the bus cycle and response
  task automatic run_cmd(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input int ack, input logic [31:0] rdat, input int exp_stb);
    logic [32:0] exp;
    logic        to;
    to = (ack == 0) || (ack > TO);
    exp_q.push_back({to, (to || we) ? 32'h0 : rdat});
    ack_at = ack;
    rd_data = rdat;
    stb_cycles = 0;
    unstable = 1'b0;
    check({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_sel = sel;
    cmd_adr = adr;
    cmd_dat = dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, " cyc"}, {31'd0, wbm_cyc}, 32'd1);
    wait_rsp(tag);
    exp = exp_q.pop_front();
    check({tag, " rsp_dat"}, rsp_dat, exp[31:0]);
    check({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp[32]});
    check({tag, " stb_cycles"}, stb_cycles, exp_stb);
    check({tag, " wbm_adr"}, obs_adr, adr);
    check({tag, " wbm_dat"}, obs_dat, dat);
    check({tag, " wbm_sel_we"}, {27'd0, obs_we, obs_sel}, {27'd0, we, sel});
    check({tag, " stable"}, {31'd0, unstable}, 32'd0);
    check({tag, " adr_idle_zero"}, wbm_adr, 32'd0);
    @(negedge clk);
    check({tag, " rsp_done"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
  endtask

  initial begin
    int   accepts;
    logic ok;

    // reset block
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outs", {26'd0, cmd_ready, rsp_valid, wbm_cyc, wbm_stb, busy, rsp_err}, 32'h20);
    check("reset bus", wbm_adr | wbm_dat_o | rsp_dat | {28'd0, wbm_sel}, 32'd0);
    rst_n = 1'b1;

    run_cmd("write", 1'b1, 4'hF, 32'h3000_0000, 32'hDEAD_BEEF, 2, 32'h5555_AAAA, 2);
    run_cmd("read", 1'b0, 4'hF, 32'h3000_0004, 32'h0, 1, 32'h1234_5678, 1);
    run_cmd("timeout", 1'b0, 4'h3, 32'h3000_0100, 32'h0, 0, 32'h7777_7777, 4);
    run_cmd("ack_last", 1'b0, 4'hC, 32'h3000_0200, 32'h0, 4, 32'hCAFE_F00D, 4);

    // accept-to-accept period with zero-wait ack and rsp_ready high
    ack_at = 1;
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h3000_0300;
    accepts = 0;
    for (int i = 0; i < 9; i++) begin
      if (cmd_valid && cmd_ready) accepts++;
      if (i == 8) cmd_valid = 1'b0;
      @(negedge clk);
    end
    check("throughput accepts", accepts, 3);
    wait_idle("throughput");

    // backpressure
    rsp_ready = 1'b0;
    ack_at = 1;
    rd_data = 32'hA5A5_5A5A;
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h3000_000C;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("bp");
    cmd_valid = 1'b1;
    cmd_adr = 32'h3000_0010;
    ok = 1'b1;
    repeat (10) begin
      if (!(rsp_valid === 1'b1 && rsp_dat === 32'hA5A5_5A5A && rsp_err === 1'b0 &&
            cmd_ready === 1'b0 && wbm_cyc === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    check("bp hold", {31'd0, ok}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp released", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp next cmd", wbm_adr, 32'h3000_0010);
    wait_idle("bp");

    // reset during the second bus cycle
    ack_at = 0;
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_adr = 32'h3000_0400;
    cmd_dat = 32'h0BAD_0BAD;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst bus1 cyc", {31'd0, wbm_cyc}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst async", {27'd0, wbm_cyc, wbm_stb, busy, rsp_valid, cmd_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst release", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    run_cmd("post_rst", 1'b0, 4'h1, 32'h3000_0008, 32'h0, 1, 32'h0F0F_1234, 1);

    // final report
    check("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
